alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit ALU between two requesters (port 0, port 1), e.g. the execute stage and an address-generation unit. It accepts one operation at a time over a valid/ready request handshake, registers the operands and drives the ALU's combinational inputs. It then captures the ALU result and carry, and returns them on the winning port's valid/ready response channel. Illegal opcodes are rejected without touching the ALU.

## Interface
- WIDTH, 16, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid0 / req_valid1  in  1  request present on port 0 / 1.
- req_ready0 / req_ready1  out  1  request accepted this cycle when valid&ready.
- op0 / op1  in  3  ALU opcode: 000 AND, 001 ADD, 010 ADD with carry-in, 110 SUB, 111 set-less-than; 011/100/101 illegal.
- x0, y0 / x1, y1  in  WIDTH  operands.
- cin0 / cin1  in  1  carry-in (used by op 010 only; forwarded for all).
- rsp_valid0 / rsp_valid1  out  1  response present.
- rsp_ready0 / rsp_ready1  in  1  requester takes response.
- rsp_data0 / rsp_data1  out  WIDTH  result.
- rsp_cout0 / rsp_cout1  out  1  ALU carry-out.
- rsp_err0 / rsp_err1  out  1  illegal opcode; data/cout forced 0.
- alu_x, alu_y  out  WIDTH  to ALU X, Y.
- alu_op  out  3  to ALU opcod.
- alu_cin  out  1  to ALU Cin.
- alu_out  in  WIDTH  from ALU out.
- alu_cout  in  1  from ALU Cout.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate. If exactly one port is valid, it wins. If both are valid, the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie. Only the winner's req_ready is high, combinationally, and only in IDLE. On handshake: latch port id, op, x, y, cin into operand registers, update last_grant, go to EXEC.
- EXEC (one cycle): alu_x/alu_y/alu_op/alu_cin driven from operand registers. At the clock edge, capture alu_out/alu_cout into the result register with err=0, then go to RESP.
  - Illegal op: the ALU inputs stay at their previous registered values (idle values). Capture data=0, cout=0, err=1.
- RESP: rsp_valid high on the latched port only; the other port's rsp_valid stays 0. Data/cout/err are held stable while waiting. On rsp_valid&rsp_ready, go to IDLE.
- No request accepted in EXEC or RESP: both req_ready low. There is no pipelining; one operation is in flight.
- Arithmetic and width behaviour belong to the ALU. The arbiter passes values through unmodified and never truncates or extends.
- ALU inputs change only on the accept edge. They hold their value through RESP and IDLE, which avoids toggling the shared datapath.
- A requester may drop req_valid before acceptance; no state effect. Changing op/x/y while valid and not ready is permitted; values at the accept edge are used.

## Timing
- Reset (rst high at a clock edge), applying also mid-operation:
  - State goes to IDLE and last_grant to 1.
  - All rsp_valid, rsp_err and rsp_cout are 0, and rsp_data is 0.
  - alu_x, alu_y, alu_op and alu_cin are 0; busy is 0.
  - An in-flight operation is dropped with no response.
- req_ready is low during the reset cycle. In the first cycle after reset, req_ready follows arbitration.
- Latency: accept at edge N. The ALU is driven during cycle N..N+1, the result is captured at edge N+1, and rsp_valid is high from edge N+1.
- The earliest rsp handshake is at edge N+2 when rsp_ready is held high. The next accept is at edge N+3, giving 3 cycles per operation at best.
- A response stall holds RESP indefinitely, and both requesters are blocked during it.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1… A single requester is served back-to-back every 3 cycles.

## Test plan
- Reset then single ADD on port 0: x0=0x1234, y0=0x0F0F, op 001.
  - req_ready0 is high on the first cycle.
  - rsp_valid0 rises 1 cycle after accept with rsp_data0=0x2143, cout=0, err=0.
  - rsp_valid1 stays 0 throughout.
- Carry: port 1 op 010, x=0xFFFF, y=0x0001, cin=1 -> rsp_data1=0x0001, rsp_cout1=1.
- Tie and fairness: both ports hold valid for 4 operations; port 0 AND 0xF0F0&0x0FF0, port 1 SUB 5-3.
  - Grant order is 0,1,0,1.
  - Responses are 0x00F0 / 0x0002.
  - busy stays high except during the IDLE cycles.
- Back-pressure: rsp_ready0 low for 5 cycles.
  - rsp_valid0 and the data are held stable throughout.
  - req_ready1 stays low throughout, although valid1 is high.
  - Port 1 is accepted the cycle after the rsp0 handshake.
- Illegal opcode 100 on port 0:
  - rsp_err0=1, data=0, cout=0.
  - alu_x/alu_y/alu_op unchanged from the prior operation.
  - The next legal operation completes normally.
- Reset asserted in EXEC, then in RESP:
  - All outputs return to 0 next cycle, with no response emitted.
  - Port 0 wins the following tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight; the result returns on the winning port's response channel.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid0,
    input  logic             req_valid1,
    output logic             req_ready0,
    output logic             req_ready1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    input  logic             rsp_ready0,
    input  logic             rsp_ready1,
    output logic [WIDTH-1:0] rsp_data0,
    output logic [WIDTH-1:0] rsp_data1,
    output logic             rsp_cout0,
    output logic             rsp_cout1,
    output logic             rsp_err0,
    output logic             rsp_err1,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic             port_r;
    logic             illegal_r;
    logic             rsp_valid0_r;
    logic             rsp_valid1_r;
    logic             rsp_cout_r;
    logic             rsp_err_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic [WIDTH-1:0] alu_x_r;
    logic [WIDTH-1:0] alu_y_r;
    logic [2:0]       alu_op_r;
    logic             alu_cin_r;

    logic             win_s;
    logic             grant_ok_s;
    logic             accept_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_x_s;
    logic [WIDTH-1:0] sel_y_s;
    logic             sel_cin_s;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    // A lone requester wins; a tie goes to the port that was not granted last
    always_comb begin
        win_s = 1'b0;
        if (req_valid0 && req_valid1) begin
            win_s = ~last_grant_r;
        end else if (req_valid1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    assign grant_ok_s = (state_r == IDLE) && !rst;
    assign req_ready0 = grant_ok_s && req_valid0 && !win_s;
    assign req_ready1 = grant_ok_s && req_valid1 && win_s;
    assign accept_s   = req_ready0 || req_ready1;

    // Winner's request fields, muxed for the operand registers
    always_comb begin
        sel_op_s  = op0;
        sel_x_s   = x0;
        sel_y_s   = y0;
        sel_cin_s = cin0;
        if (win_s) begin
            sel_op_s  = op1;
            sel_x_s   = x1;
            sel_y_s   = y1;
            sel_cin_s = cin1;
        end else begin
            sel_op_s  = op0;
            sel_x_s   = x0;
            sel_y_s   = y0;
            sel_cin_s = cin0;
        end
    end

    // Sequencer: accept, drive the ALU for one cycle, hold the response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            port_r       <= 1'b0;
            illegal_r    <= 1'b0;
            rsp_valid0_r <= 1'b0;
            rsp_valid1_r <= 1'b0;
            rsp_cout_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp_data_r   <= {WIDTH{1'b0}};
            alu_x_r      <= {WIDTH{1'b0}};
            alu_y_r      <= {WIDTH{1'b0}};
            alu_op_r     <= 3'b000;
            alu_cin_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        port_r       <= win_s;
                        last_grant_r <= win_s;
                        illegal_r    <= !op_legal(sel_op_s);
                        // Illegal ops leave the shared ALU inputs untouched
                        if (op_legal(sel_op_s)) begin
                            alu_x_r   <= sel_x_s;
                            alu_y_r   <= sel_y_s;
                            alu_op_r  <= sel_op_s;
                            alu_cin_r <= sel_cin_s;
                        end
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (illegal_r) begin
                        rsp_data_r <= {WIDTH{1'b0}};
                        rsp_cout_r <= 1'b0;
                        rsp_err_r  <= 1'b1;
                    end else begin
                        rsp_data_r <= alu_out;
                        rsp_cout_r <= alu_cout;
                        rsp_err_r  <= 1'b0;
                    end
                    rsp_valid0_r <= !port_r;
                    rsp_valid1_r <= port_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if ((port_r && rsp_ready1) || (!port_r && rsp_ready0)) begin
                        rsp_valid0_r <= 1'b0;
                        rsp_valid1_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid0 = rsp_valid0_r;
    assign rsp_valid1 = rsp_valid1_r;
    assign rsp_data0  = rsp_data_r;
    assign rsp_data1  = rsp_data_r;
    assign rsp_cout0  = rsp_cout_r;
    assign rsp_cout1  = rsp_cout_r;
    assign rsp_err0   = rsp_err_r;
    assign rsp_err1   = rsp_err_r;
    assign alu_x      = alu_x_r;
    assign alu_y      = alu_y_r;
    assign alu_op     = alu_op_r;
    assign alu_cin    = alu_cin_r;
    assign busy       = (state_r != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: op-queue driver, behavioural ALU, and a cycle monitor
// that compares the DUT against a transaction-level model and scoreboard.
module tb_alu_arbiter;
    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
    } op_t;

    typedef struct {
        int          port;
        logic [15:0] data;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic        req_ready0, req_ready1;
    logic [2:0]  op0 = 3'b000, op1 = 3'b000;
    logic [15:0] x0 = 16'h0000, y0 = 16'h0000, x1 = 16'h0000, y1 = 16'h0000;
    logic        cin0 = 1'b0, cin1 = 1'b0;
    logic        rsp_valid0, rsp_valid1;
    logic        rsp_ready0 = 1'b1, rsp_ready1 = 1'b1;
    logic [15:0] rsp_data0, rsp_data1;
    logic        rsp_cout0, rsp_cout1, rsp_err0, rsp_err1;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_cout, busy;
    logic [17:0] alu_res;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    int acc_count = 0;

    op_t  opq0[$];
    op_t  opq1[$];
    exp_t sbq[$];

    alu_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .op0(op0), .op1(op1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .cin0(cin0), .cin1(cin1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_cout0(rsp_cout0), .rsp_cout1(rsp_cout1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // {err, cout, data} of one operation computed with plain arithmetic
    function automatic logic [17:0] ref_alu(input logic [2:0] op, input logic [15:0] x,
                                            input logic [15:0] y, input logic c);
        int unsigned s;
        logic [15:0] ny;
        ny = ~y;
        s  = 0;
        case (op)
            3'b000: return {2'b00, x & y};
            3'b001: s = 32'(x) + 32'(y);
            3'b010: s = 32'(x) + 32'(y) + 32'(c);
            3'b110: s = 32'(x) + 32'(ny) + 32'd1;
            3'b111: return {2'b00, 15'd0, ($signed(x) < $signed(y))};
            default: return {1'b1, 17'd0};
        endcase
        return {1'b0, s[16], s[15:0]};
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd6) || (op == 3'd7);
    endfunction

    // Shared ALU seen by the arbiter
    always_comb begin
        alu_res  = ref_alu(alu_op, alu_x, alu_y, alu_cin);
        alu_out  = alu_res[15:0];
        alu_cout = alu_res[16];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Request driver: present the queue heads, pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && req_valid0 && req_ready0 && opq0.size() > 0) void'(opq0.pop_front());
            if (!rst && req_valid1 && req_ready1 && opq1.size() > 0) void'(opq1.pop_front());
            @(posedge clk);
            #1;
            if (opq0.size() > 0) begin
                req_valid0 = 1'b1; op0 = opq0[0].op; x0 = opq0[0].x; y0 = opq0[0].y; cin0 = opq0[0].cin;
            end else begin
                req_valid0 = 1'b0;
            end
            if (opq1.size() > 0) begin
                req_valid1 = 1'b1; op1 = opq1[0].op; x1 = opq1[0].x; y1 = opq1[0].y; cin1 = opq1[0].cin;
            end else begin
                req_valid1 = 1'b0;
            end
        end
    end

    // Response-ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin rsp_ready0 = ($urandom_range(0, 3) != 0); rsp_ready1 = ($urandom_range(0, 3) != 0); end
                2: begin rsp_ready0 = 1'b0; rsp_ready1 = 1'b1; end
                3: begin rsp_ready0 = 1'b0; rsp_ready1 = 1'b0; end
                default: begin rsp_ready0 = 1'b1; rsp_ready1 = 1'b1; end
            endcase
        end
    end

    // Monitor: transaction-level model of grant, flight, and response timing
    int          cyc = 0;
    int          acc_cyc = 0;
    int          port_m = 0;
    int          last_m = 1;
    bit          inflight_m = 0;
    bit          prev_rst = 0;
    logic [15:0] ex_x = 16'h0, ex_y = 16'h0;
    logic [2:0]  ex_op = 3'b000;
    logic        ex_cin = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) begin
                chk("rst_rsp_valid", {rsp_valid1, rsp_valid0}, 2'b00);
                chk("rst_rsp_data", {rsp_data1, rsp_data0}, 32'h0);
                chk("rst_rsp_flags", {rsp_cout1, rsp_cout0, rsp_err1, rsp_err0}, 4'h0);
                chk("rst_alu", {alu_x, alu_y, alu_op, alu_cin}, 36'h0);
                chk("rst_busy", busy, 1'b0);
            end
            if (rst) begin
                chk("ready_in_rst", {req_ready1, req_ready0}, 2'b00);
                inflight_m = 0;
                last_m = 1;
                sbq.delete();
                ex_x = 16'h0; ex_y = 16'h0; ex_op = 3'b000; ex_cin = 1'b0;
            end else begin
                bit resp_ph;
                resp_ph = inflight_m && (cyc >= acc_cyc + 2);
                chk("busy", busy, inflight_m);
                chk("alu_inputs", {alu_x, alu_y, alu_op, alu_cin}, {ex_x, ex_y, ex_op, ex_cin});
                chk("rsp_valid", {rsp_valid1, rsp_valid0},
                    {resp_ph && port_m == 1, resp_ph && port_m == 0});
                if (resp_ph && sbq.size() > 0) begin
                    chk("rsp_port", port_m, sbq[0].port);
                    if (port_m == 1)
                        chk("rsp1_payload", {rsp_err1, rsp_cout1, rsp_data1}, {sbq[0].err, sbq[0].cout, sbq[0].data});
                    else
                        chk("rsp0_payload", {rsp_err0, rsp_cout0, rsp_data0}, {sbq[0].err, sbq[0].cout, sbq[0].data});
                end
                if (inflight_m) begin
                    chk("ready_while_busy", {req_ready1, req_ready0}, 2'b00);
                    if (resp_ph && ((port_m == 1) ? rsp_ready1 : rsp_ready0)) begin
                        if (sbq.size() > 0) void'(sbq.pop_front());
                        inflight_m = 0;
                    end
                end else begin
                    int exp_w;
                    int acc_p;
                    exp_w = (req_valid0 && req_valid1) ? (1 - last_m) : (req_valid1 ? 1 : 0);
                    chk("ready_grant", {req_ready1, req_ready0},
                        {req_valid1 && exp_w == 1, req_valid0 && exp_w == 0});
                    acc_p = (req_valid1 && req_ready1) ? 1 : ((req_valid0 && req_ready0) ? 0 : -1);
                    if (acc_p >= 0) begin
                        exp_t e;
                        logic [17:0] r;
                        logic [2:0]  a_op;
                        logic [15:0] a_x, a_y;
                        logic        a_c;
                        a_op = (acc_p == 1) ? op1 : op0;
                        a_x  = (acc_p == 1) ? x1 : x0;
                        a_y  = (acc_p == 1) ? y1 : y0;
                        a_c  = (acc_p == 1) ? cin1 : cin0;
                        r = ref_alu(a_op, a_x, a_y, a_c);
                        e.port = acc_p; e.data = r[15:0]; e.cout = r[16]; e.err = r[17];
                        sbq.push_back(e);
                        inflight_m = 1;
                        acc_cyc = cyc;
                        port_m = acc_p;
                        last_m = acc_p;
                        acc_count++;
                        if (is_legal(a_op)) begin
                            ex_x = a_x; ex_y = a_y; ex_op = a_op; ex_cin = a_c;
                        end
                    end
                end
            end
            prev_rst = rst;
        end
    end

    function automatic op_t mk(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y, input logic c);
        op_t o;
        o.op = op; o.x = x; o.y = y; o.cin = c;
        return o;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (opq0.size() == 0 && opq1.size() == 0 && sbq.size() == 0 && !inflight_m) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_%s pending0=%0d pending1=%0d sb=%0d", name, opq0.size(), opq1.size(), sbq.size());
    endtask

    task automatic wait_acc(input int n0, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (acc_count != n0) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_acc_%s accepts=%0d expected>%0d", name, acc_count, n0);
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        opq0.push_back(mk(3'b001, 16'h1234, 16'h0F0F, 1'b0));
        wait_idle(50, "add0");
        opq1.push_back(mk(3'b010, 16'hFFFF, 16'h0001, 1'b1));
        wait_idle(50, "carry1");

        @(negedge clk); #2;
        for (int i = 0; i < 2; i++) begin
            opq0.push_back(mk(3'b000, 16'hF0F0, 16'h0FF0, 1'b0));
            opq1.push_back(mk(3'b110, 16'h0005, 16'h0003, 1'b0));
        end
        wait_idle(100, "tie");

        rdy_mode = 2;
        @(negedge clk); #2;
        opq0.push_back(mk(3'b001, 16'hAAAA, 16'h5555, 1'b0));
        opq1.push_back(mk(3'b111, 16'h8000, 16'h0001, 1'b0));
        repeat (8) @(posedge clk);
        #1 rdy_mode = 0;
        wait_idle(50, "backpressure");

        opq0.push_back(mk(3'b100, 16'h1111, 16'h2222, 1'b1));
        wait_idle(50, "illegal");
        opq0.push_back(mk(3'b001, 16'h0001, 16'h0002, 1'b0));
        wait_idle(50, "after_illegal");

        n0 = acc_count;
        opq0.push_back(mk(3'b001, 16'h0100, 16'h0200, 1'b0));
        wait_acc(n0, "exec");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        #1 rdy_mode = 3;
        n0 = acc_count;
        opq1.push_back(mk(3'b010, 16'h7FFF, 16'h0001, 1'b1));
        wait_acc(n0, "resp");
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rdy_mode = 0;
        opq0.push_back(mk(3'b000, 16'h00FF, 16'h0F0F, 1'b0));
        opq1.push_back(mk(3'b001, 16'h0003, 16'h0004, 1'b0));
        wait_idle(50, "tie_after_rst");

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(1, 3);
            @(negedge clk); #2;
            for (int j = 0; j < n; j++) begin
                op_t o;
                o = mk(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
                if ($urandom_range(0, 1) == 1) opq1.push_back(o);
                else opq0.push_back(o);
            end
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(5000, "random");
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
